lsu_fsm: RTL and testbench

- Load/store unit that consumes the memory-control fields produced by instruction decode (MemWr, MemOP, and the load indication where RegSrc==1) together with the EX-stage address and store data.
- Issues one aligned 64-bit transaction to data memory over a valid/ready request / valid response interface.
- Aligns store data and builds the byte mask; extracts and extends load data before handing the result to writeback.
- Sits between EX and WB in the npc core.

---
 rtl/lsu_fsm.sv | 163 ++++++++++++++++
 tb/tb_lsu_fsm.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_fsm.sv
// Load/store unit: issues one aligned 64-bit memory transaction per EX op,
// places store bytes on their lanes and sign/zero-extends load results for WB.
module lsu_fsm #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic                MemWr,
  input  logic                MemRd,
  input  logic [2:0]          MemOP,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [DATA_W-1:0]   wb_data,
  output logic                wb_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t              state;
  logic [2:0]          opReg;
  logic [2:0]          offReg;
  logic                isStore;
  logic                exReady, reqValid, reqWen, wbValid, wbErr;
  logic [ADDR_W-1:0]   reqAddr;
  logic [DATA_W-1:0]   reqWdata, wbData;
  logic [DATA_W/8-1:0] reqWmask;

  // Accept-time decode: alignment, lane mask and lane-shifted store data.
  logic                misaligned, isErr, isNoop;
  logic [DATA_W/8-1:0] stMask;
  logic [DATA_W-1:0]   stData;

  always_comb begin
    misaligned = 1'b0;
    stMask     = '0;
    stData     = '0;
    case (MemOP[1:0])
      2'b00: begin
        misaligned = (addr[2:0] != 3'b000);
        stMask     = 8'hFF;
        stData     = wdata;
      end
      2'b01: begin
        misaligned = (addr[1:0] != 2'b00);
        stMask     = 8'h0F << addr[2:0];
        stData     = {32'b0, wdata[31:0]} << {addr[2:0], 3'b000};
      end
      2'b10: begin
        misaligned = addr[0];
        stMask     = 8'h03 << addr[2:0];
        stData     = {48'b0, wdata[15:0]} << {addr[2:0], 3'b000};
      end
      default: begin
        stMask     = 8'h01 << addr[2:0];
        stData     = {56'b0, wdata[7:0]} << {addr[2:0], 3'b000};
      end
    endcase
    isNoop = ~MemWr & ~MemRd;
    isErr  = (MemWr & MemRd) | (MemOP == 3'b000) | misaligned;
  end

  // Load extraction from the registered offset/op of the outstanding access.
  logic [DATA_W-1:0] shifted, loadExt;

  always_comb begin
    shifted = mem_resp_rdata >> {offReg, 3'b000};
    case (opReg[1:0])
      2'b11:   loadExt = {{56{opReg[2] & shifted[7]}},  shifted[7:0]};
      2'b10:   loadExt = {{48{opReg[2] & shifted[15]}}, shifted[15:0]};
      2'b01:   loadExt = {{32{opReg[2] & shifted[31]}}, shifted[31:0]};
      default: loadExt = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      opReg    <= '0;
      offReg   <= '0;
      isStore  <= 1'b0;
      exReady  <= 1'b1;
      reqValid <= 1'b0;
      reqWen   <= 1'b0;
      reqAddr  <= '0;
      reqWdata <= '0;
      reqWmask <= '0;
      wbValid  <= 1'b0;
      wbErr    <= 1'b0;
      wbData   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ex_valid) begin
            opReg    <= MemOP;
            offReg   <= addr[2:0];
            isStore  <= MemWr;
            reqAddr  <= {addr[ADDR_W-1:3], 3'b000};
            reqWen   <= MemWr;
            reqWdata <= MemWr ? stData : '0;
            reqWmask <= MemWr ? stMask : '0;
            exReady  <= 1'b0;
            wbData   <= '0;
            if (isNoop || isErr) begin
              // No memory traffic: report straight to writeback.
              state   <= S_DONE;
              wbValid <= 1'b1;
              wbErr   <= ~isNoop;
            end else begin
              state    <= S_REQ;
              reqValid <= 1'b1;
              wbErr    <= 1'b0;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            reqValid <= 1'b0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            wbData  <= isStore ? '0 : loadExt;
            wbErr   <= 1'b0;
            wbValid <= 1'b1;
            state   <= S_DONE;
          end
        end
        default: begin
          if (wb_ready) begin
            wbValid <= 1'b0;
            exReady <= 1'b1;
            state   <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign ex_ready      = exReady;
  assign mem_req_valid = reqValid;
  assign mem_req_addr  = reqAddr;
  assign mem_req_wen   = reqWen;
  assign mem_req_wdata = reqWdata;
  assign mem_req_wmask = reqWmask;
  assign wb_valid      = wbValid;
  assign wb_data       = wbData;
  assign wb_err        = wbErr;

endmodule

// File: tb/tb_lsu_fsm.sv
// Directed bench for lsu_fsm: loads, stores, error/no-op paths, backpressure
// on both sides and reset while a response is outstanding.
module tb_lsu_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, MemWr, MemRd;
  logic [2:0]  MemOP;
  logic [63:0] addr, wdata;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;
  logic        wb_valid, wb_ready, wb_err;
  logic [63:0] wb_data;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  lsu_fsm #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .MemWr(MemWr), .MemRd(MemRd), .MemOP(MemOP), .addr(addr), .wdata(wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_err(wb_err)
  );

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the LSU idle; returns at the negedge after accept.
  task automatic issue(input string tag, input logic wr, input logic rd,
                       input logic [2:0] op, input logic [63:0] a, input logic [63:0] d);
    checkEq({tag, "_ex_ready_idle"}, ex_ready, 1'b1);
    MemWr = wr; MemRd = rd; MemOP = op; addr = a; wdata = d; ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  task automatic doLoad(input string tag, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] rdata, input logic [63:0] exp, input int holdWb);
    mem_req_ready = 1'b1;
    issue(tag, 1'b0, 1'b1, op, a, 64'h0);
    checkEq({tag, "_req_valid"}, mem_req_valid, 1'b1);
    checkEq({tag, "_req_addr"}, mem_req_addr, {a[63:3], 3'b000});
    checkEq({tag, "_req_wen"}, mem_req_wen, 1'b0);
    checkEq({tag, "_req_wmask"}, mem_req_wmask, 8'h00);
    checkEq({tag, "_ex_ready_busy"}, ex_ready, 1'b0);
    @(negedge clk);
    checkEq({tag, "_req_drop"}, mem_req_valid, 1'b0);
    checkEq({tag, "_wb_early"}, wb_valid, 1'b0);
    mem_resp_valid = 1'b1; mem_resp_rdata = rdata;
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_resp_rdata = 64'h0;
    checkEq({tag, "_wb_valid"}, wb_valid, 1'b1);
    checkEq({tag, "_wb_data"}, wb_data, exp);
    checkEq({tag, "_wb_err"}, wb_err, 1'b0);
    for (int i = 0; i < holdWb; i++) begin
      ex_valid = 1'b1; MemWr = 1'b0; MemRd = 1'b1; MemOP = 3'b111; addr = 64'h0;
      @(negedge clk);
      checkEq({tag, "_hold_wb_valid"}, wb_valid, 1'b1);
      checkEq({tag, "_hold_wb_data"}, wb_data, exp);
      checkEq({tag, "_hold_ex_ready"}, ex_ready, 1'b0);
      checkEq({tag, "_hold_no_req"}, mem_req_valid, 1'b0);
    end
    ex_valid = 1'b0; wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    checkEq({tag, "_wb_clear"}, wb_valid, 1'b0);
    checkEq({tag, "_ex_ready_back"}, ex_ready, 1'b1);
    $display("[TB] %s addr=0x%016h wb_data=0x%016h", tag, a, wb_data);
  endtask

  task automatic doStore(input string tag, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] d, input logic [7:0] expMask,
                         input logic [63:0] expData, input int reqHold);
    mem_req_ready = (reqHold == 0);
    issue(tag, 1'b1, 1'b0, op, a, d);
    for (int i = 0; i <= reqHold; i++) begin
      checkEq({tag, "_req_valid"}, mem_req_valid, 1'b1);
      checkEq({tag, "_req_addr"}, mem_req_addr, {a[63:3], 3'b000});
      checkEq({tag, "_req_wen"}, mem_req_wen, 1'b1);
      checkEq({tag, "_req_wmask"}, mem_req_wmask, expMask);
      checkEq({tag, "_req_wdata"}, mem_req_wdata, expData);
      checkEq({tag, "_ex_ready_busy"}, ex_ready, 1'b0);
      mem_req_ready = (i == reqHold);
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    checkEq({tag, "_req_drop"}, mem_req_valid, 1'b0);
    mem_resp_valid = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    checkEq({tag, "_wb_valid"}, wb_valid, 1'b1);
    checkEq({tag, "_wb_data"}, wb_data, 64'h0);
    checkEq({tag, "_wb_err"}, wb_err, 1'b0);
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    checkEq({tag, "_wb_clear"}, wb_valid, 1'b0);
    $display("[TB] %s addr=0x%016h wmask=0x%02h wdata=0x%016h", tag, a, expMask, expData);
  endtask

  task automatic doShort(input string tag, input logic wr, input logic rd,
                         input logic [2:0] op, input logic [63:0] a, input logic expErr);
    issue(tag, wr, rd, op, a, 64'hFFFF_FFFF_FFFF_FFFF);
    checkEq({tag, "_wb_valid"}, wb_valid, 1'b1);
    checkEq({tag, "_wb_err"}, wb_err, expErr);
    checkEq({tag, "_wb_data"}, wb_data, 64'h0);
    checkEq({tag, "_no_req"}, mem_req_valid, 1'b0);
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    checkEq({tag, "_wb_clear"}, wb_valid, 1'b0);
    checkEq({tag, "_no_req_after"}, mem_req_valid, 1'b0);
    $display("[TB] %s addr=0x%016h wb_err=%0b", tag, a, expErr);
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; MemWr = 1'b0; MemRd = 1'b0; MemOP = 3'b000;
    addr = 64'h0; wdata = 64'h0; mem_req_ready = 1'b1; mem_resp_valid = 1'b0;
    mem_resp_rdata = 64'h0; wb_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkEq("rst_ex_ready", ex_ready, 1'b1);
    checkEq("rst_req_valid", mem_req_valid, 1'b0);
    checkEq("rst_wb_valid", wb_valid, 1'b0);
    checkEq("rst_wb_data", wb_data, 64'h0);
    checkEq("rst_wmask", mem_req_wmask, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    doLoad("lb",  3'b111, 64'h8000_0005, 64'h0000_8000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80, 0);
    doLoad("lbu", 3'b011, 64'h8000_0005, 64'h0000_8000_0000_0000, 64'h0000_0000_0000_0080, 0);
    doLoad("lhu", 3'b010, 64'h8000_0006, 64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF, 4);
    doShort("nop_after_bp", 1'b0, 1'b0, 3'b000, 64'h8000_0000, 1'b0);
    doLoad("lw",  3'b101, 64'h8000_0004, 64'h8000_0001_1234_5678, 64'hFFFF_FFFF_8000_0001, 0);
    doLoad("lwu", 3'b001, 64'h8000_0004, 64'h8000_0001_1234_5678, 64'h0000_0000_8000_0001, 0);
    doLoad("lh",  3'b110, 64'h8000_0002, 64'h0000_0000_F00D_0000, 64'hFFFF_FFFF_FFFF_F00D, 0);
    doLoad("ld",  3'b100, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 0);

    doStore("sh", 3'b010, 64'h8000_0002, 64'h0000_0000_0000_1234, 8'h0C, 64'h0000_0000_1234_0000, 3);
    doStore("sb", 3'b011, 64'h8000_0007, 64'hFFFF_FFFF_FFFF_FFAB, 8'h80, 64'hAB00_0000_0000_0000, 0);
    doStore("sw", 3'b001, 64'h8000_0004, 64'hFFFF_FFFF_DEAD_BEEF, 8'hF0, 64'hDEAD_BEEF_0000_0000, 1);
    doStore("sd", 3'b100, 64'h8000_0010, 64'hCAFE_F00D_1234_5678, 8'hFF, 64'hCAFE_F00D_1234_5678, 0);

    doShort("sd_misaligned", 1'b1, 1'b0, 3'b100, 64'h8000_0004, 1'b1);
    doShort("op_invalid",    1'b1, 1'b0, 3'b000, 64'h8000_0000, 1'b1);
    doShort("wr_and_rd",     1'b1, 1'b1, 3'b100, 64'h8000_0000, 1'b1);
    doShort("lh_misaligned", 1'b0, 1'b1, 3'b110, 64'h8000_0001, 1'b1);

    // Abort while a response is outstanding; the late response must be dropped.
    mem_req_ready = 1'b1;
    issue("rst_wait", 1'b0, 1'b1, 3'b100, 64'h8000_0010, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkEq("rst_wait_ex_ready", ex_ready, 1'b1);
    checkEq("rst_wait_req_valid", mem_req_valid, 1'b0);
    checkEq("rst_wait_wb_valid", wb_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    mem_resp_valid = 1'b0; mem_resp_rdata = 64'h0;
    for (int i = 0; i < 2; i++) begin
      checkEq("stale_wb_valid", wb_valid, 1'b0);
      checkEq("stale_wb_data", wb_data, 64'h0);
      checkEq("stale_wb_err", wb_err, 1'b0);
      checkEq("stale_ex_ready", ex_ready, 1'b1);
      checkEq("stale_req_valid", mem_req_valid, 1'b0);
      @(negedge clk);
    end
    $display("[TB] rst_wait stale response dropped");

    doLoad("ld_after_rst", 3'b100, 64'h8000_0018, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
